// File: rtl/uart_kb_pkg.sv
// Shared types and constants for the key-to-UART transmit buffer.
package uart_kb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        TERM      = 3'd4
    } state_t;

    localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h0D;

    localparam logic MODE_BATCH = 1'b0;
    localparam logic MODE_AUTO  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; flush wins over push.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [DATA_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_wr;
    logic              w_rd;
    logic [AW:0]       w_count_nxt;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_wr = i_push && (!r_full || i_pop) && !i_flush;
    assign w_rd = i_pop && !r_empty && !i_flush;

    // Next occupancy from this cycle's accepted push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
                2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_key_buffer.sv
// Queues decoded key codes and feeds them to a UART transmitter via send/busy,
// either per key (auto) or as a drained batch with optional terminator.
module uart_tx_key_buffer
    import uart_kb_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter bit                TERM_EN   = 1'b1,
    parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(TERM_CHAR_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        key_data,
    input  logic                     key_valid,
    input  logic                     send,
    input  logic                     mode,
    input  logic                     clear,
    input  logic                     tx_busy,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_send,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     draining
);

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_send;
    logic                r_overflow;
    logic                r_draining;
    logic                r_batch_mode;
    logic                r_clear_pend;
    logic                r_term_flag;

    logic                w_pop;
    logic                w_push_ok;
    logic [DATA_W-1:0]   w_head;
    logic                w_full;
    logic                w_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (key_valid),
        .i_data  (key_data),
        .i_pop   (w_pop),
        .i_flush (clear),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push_ok = key_valid && (!w_full || w_pop);

    // Next-state decode; clear blocks a new LOAD so an emptied FIFO is never popped.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!clear && !w_empty && ((mode == MODE_AUTO) || send)) begin
                    w_next = LOAD;
                end else begin
                    w_next = IDLE;
                end
            end
            LOAD: begin
                w_pop  = 1'b1;
                w_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    w_next = WAIT_DONE;
                end else begin
                    w_next = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (tx_busy) begin
                    w_next = WAIT_DONE;
                end else if (r_clear_pend || clear || r_term_flag) begin
                    w_next = IDLE;
                end else if (!w_empty) begin
                    w_next = LOAD;
                end else if (r_batch_mode && TERM_EN) begin
                    w_next = TERM;
                end else begin
                    w_next = IDLE;
                end
            end
            TERM: begin
                w_next = WAIT_ACK;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, registered outputs and sticky/pending flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tx_data    <= '0;
            r_tx_send    <= 1'b0;
            r_overflow   <= 1'b0;
            r_draining   <= 1'b0;
            r_batch_mode <= 1'b0;
            r_clear_pend <= 1'b0;
            r_term_flag  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_send  <= (w_next == LOAD) || (w_next == TERM);
            r_draining <= (w_next != IDLE);
            if (w_next == LOAD) begin
                r_tx_data <= w_head;
            end else if (w_next == TERM) begin
                r_tx_data <= TERM_CHAR;
            end
            if ((r_state == IDLE) && (w_next == LOAD)) begin
                r_batch_mode <= (mode == MODE_BATCH);
            end
            if (w_next == IDLE) begin
                r_clear_pend <= 1'b0;
            end else if (clear && (r_state != IDLE)) begin
                r_clear_pend <= 1'b1;
            end
            if (w_next == IDLE) begin
                r_term_flag <= 1'b0;
            end else if (r_state == TERM) begin
                r_term_flag <= 1'b1;
            end
            if (clear) begin
                r_overflow <= 1'b0;
            end else if (key_valid && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_send  = r_tx_send;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign draining = r_draining;

endmodule

// File: tb/tb_uart_tx_key_buffer.sv
// Directed bench for uart_tx_key_buffer (DEPTH=4) with a simple busy-echo UART model.
module tb_uart_tx_key_buffer;

    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic       key_valid = 1'b0;
    logic       send = 1'b0;
    logic       mode = 1'b0;
    logic       clear = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       draining;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_busy_viol = 0;
    int         busy_cnt = 0;
    logic [7:0] q_tx[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_key_buffer #(
        .DATA_W    (8),
        .DEPTH     (4),
        .TERM_EN   (1'b1),
        .TERM_CHAR (8'h0D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_data  (key_data),
        .key_valid (key_valid),
        .send      (send),
        .mode      (mode),
        .clear     (clear),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .draining  (draining)
    );

    // UART model: logs each byte, raises busy the cycle after tx_send for BUSY_LEN cycles.
    always @(posedge clk) begin
        if (tx_send) begin
            q_tx.push_back(tx_data);
            if (tx_busy) n_busy_viol <= n_busy_viol + 1;
            busy_cnt <= BUSY_LEN;
            tx_busy  <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_key(input logic [7:0] d);
        key_valid = 1'b1;
        key_data  = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!draining) break;
            tick();
        end
        check(tag, 32'(draining), 32'd0);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(q_tx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < q_tx.size()) ? 32'(q_tx[i]) : 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_draining", 32'(draining), 32'd0);
        rst = 1'b0;
        tick();

        // Auto mode: single key, tx_send in cycle 2, no terminator
        mode = 1'b1;
        q_tx.delete();
        key_valid = 1'b1;
        key_data  = 8'h31;
        tick();
        key_valid = 1'b0;
        check("auto_empty_c1", 32'(empty), 32'd0);
        check("auto_send_c1", 32'(tx_send), 32'd0);
        tick();
        check("auto_send_c2", 32'(tx_send), 32'd1);
        check("auto_data_c2", 32'(tx_data), 32'h31);
        check("auto_drain_c2", 32'(draining), 32'd1);
        wait_idle("auto_idle");
        check("auto_busy_low", 32'(tx_busy), 32'd0);
        exp_q = '{8'h31};
        check_log("auto_log");
        mode = 1'b0;
        tick();

        // Batch mode: three keys then send, terminator appended
        push_key(8'h41);
        push_key(8'h42);
        push_key(8'h43);
        check("batch_count", 32'(count), 32'd3);
        q_tx.delete();
        send = 1'b1;
        tick();
        send = 1'b0;
        check("batch_send_n1", 32'(tx_send), 32'd1);
        check("batch_data_n1", 32'(tx_data), 32'h41);
        wait_idle("batch_idle");
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h0D};
        check_log("batch_log");
        check("batch_no_busy_send", 32'(n_busy_viol), 32'd0);

        // Overflow with DEPTH=4
        push_key(8'h51);
        push_key(8'h52);
        push_key(8'h53);
        push_key(8'h54);
        push_key(8'h55);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        q_tx.delete();
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_idle("ovf_idle");
        exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h0D};
        check_log("ovf_log");
        check("ovf_sticky", 32'(overflow), 32'd1);
        push_key(8'h56);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);

        // Full FIFO: push in the LOAD cycle is accepted
        push_key(8'h61);
        push_key(8'h62);
        push_key(8'h63);
        push_key(8'h64);
        check("fpop_full", 32'(full), 32'd1);
        q_tx.delete();
        send = 1'b1;
        tick();
        send = 1'b0;
        key_valid = 1'b1;
        key_data  = 8'h65;
        check("fpop_load", 32'(tx_send), 32'd1);
        tick();
        key_valid = 1'b0;
        check("fpop_count", 32'(count), 32'd4);
        check("fpop_overflow", 32'(overflow), 32'd0);
        wait_idle("fpop_idle");
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h0D};
        check_log("fpop_log");

        // clear during WAIT_DONE of byte 2 of 4
        push_key(8'h71);
        push_key(8'h72);
        push_key(8'h73);
        push_key(8'h74);
        q_tx.delete();
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (q_tx.size() == 2 && tx_busy) break;
            tick();
        end
        check("mclr_reach", 32'(q_tx.size()), 32'd2);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mclr_count", 32'(count), 32'd0);
        check("mclr_drain", 32'(draining), 32'd1);
        wait_idle("mclr_idle");
        exp_q = '{8'h71, 8'h72};
        check_log("mclr_log");
        check("mclr_no_busy_send", 32'(n_busy_viol), 32'd0);

        // Reset during WAIT_ACK, then send on an empty FIFO
        push_key(8'h81);
        push_key(8'h82);
        q_tx.delete();
        send = 1'b1;
        tick();
        send = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_tx_send", 32'(tx_send), 32'd0);
        check("mrst_tx_data", 32'(tx_data), 32'h00);
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_full", 32'(full), 32'd0);
        check("mrst_overflow", 32'(overflow), 32'd0);
        check("mrst_draining", 32'(draining), 32'd0);
        for (int i = 0; i < 50; i++) begin
            if (!tx_busy) break;
            tick();
        end
        check("mrst_busy_end", 32'(tx_busy), 32'd0);
        send = 1'b1;
        tick();
        send = 1'b0;
        check("empty_send_a", 32'(tx_send), 32'd0);
        tick();
        check("empty_send_b", 32'(tx_send), 32'd0);
        check("empty_send_drain", 32'(draining), 32'd0);
        check("empty_send_log", 32'(q_tx.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_key_buffer.md
# uart_tx_key_buffer

Buffered key-to-UART transmit scheduler: sits between the matrix keyboard decoder and the UART transmitter. It queues decoded key codes in a parametrised FIFO and feeds them to the transmitter with a send/busy handshake. In auto mode each key is sent as it arrives; in batch mode keys accumulate until a send pulse, then the whole queue drains, optionally followed by a terminator character. It supersedes the single-key, send-on-button path.

## Interface
Parameters:
- DATA_W, 8, key code / UART payload width
- DEPTH, 16, FIFO entries; power of two, at least 2
- TERM_EN, 1, 1 = append TERM_CHAR after each batch-mode drain
- TERM_CHAR, 8'h0D, terminator byte, DATA_W wide

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- key_data  in  DATA_W  decoded key code
- key_valid  in  1  one-cycle strobe; key_data is valid
- send  in  1  one-shot, debounced; starts a batch drain
- mode  in  1  0 = batch, 1 = auto
- clear  in  1  one-cycle flush request
- tx_busy  in  1  UART transmitter busy
- tx_data  out  DATA_W  byte presented to the UART
- tx_send  out  1  one-cycle transmit strobe
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky; a key was dropped
- draining  out  1  FSM is not in IDLE

## Operation
- Push: key_valid is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A rejected key sets overflow.
  - overflow clears only on rst or clear.
- FSM states are IDLE, LOAD, WAIT_ACK, WAIT_DONE and TERM.
- IDLE:
  - Go to LOAD if (mode=1 and !empty) or (mode=0 and send and !empty).
  - Latch mode into batch_mode on this transition.
  - send is ignored outside IDLE, and ignored when empty.
- LOAD:
  - Pop the FIFO head into the tx_data register.
  - Assert tx_send for exactly this cycle, then go to WAIT_ACK.
- WAIT_ACK: hold until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: hold until tx_busy=0, then choose the next state:
  - If clear_pend is set, go to IDLE.
  - Else if the FIFO is not empty, go to LOAD; this holds in both modes.
  - Else if batch_mode and TERM_EN, go to TERM.
  - Otherwise go to IDLE.
- TERM:
  - Set tx_data=TERM_CHAR and pulse tx_send for one cycle.
  - Go to WAIT_ACK with term_flag set.
  - After that byte's WAIT_DONE, go to IDLE; the FIFO is not re-examined.
- clear:
  - In IDLE it empties the FIFO next cycle.
  - Otherwise it sets clear_pend, and the FIFO flushes at once.
  - The in-flight byte completes; no terminator is sent; then the FSM goes to IDLE.
- A mode change mid-batch has no effect until the next IDLE.
- Keys arriving during a drain are queued. In batch mode they are sent in the same drain.

## Timing
- Reset values:
  - tx_data=0, tx_send=0, count=0, empty=1, full=0, overflow=0, draining=0.
  - FSM goes to IDLE; clear_pend=0, term_flag=0.
- Reset mid-transfer: tx_send is low from the next cycle. The in-flight UART frame is not aborted by this block.
- Auto-mode latency:
  - key_valid in cycle 0 gives empty=0 in cycle 1 and LOAD (tx_send=1) in cycle 2.
- Batch-mode latency: send in cycle n gives tx_send in cycle n+1.
- tx_data is stable from the tx_send cycle until WAIT_DONE exits.
- Back-to-back bytes: the next tx_send comes 1 cycle after tx_busy falls.
- count, full and empty are registered and reflect the pushes and pops of the prior edge.
- A simultaneous push and pop leaves count unchanged.
- FIFO pointers wrap modulo DEPTH.

## Structure
- Package uart_kb_pkg holds:
  - the state enum (IDLE, LOAD, WAIT_ACK, WAIT_DONE, TERM);
  - the default TERM_CHAR constant;
  - the mode encodings MODE_BATCH=0 and MODE_AUTO=1.
- Sub-module sync_fifo(DATA_W, DEPTH):
  - synchronous first-word-fall-through FIFO with push, pop, flush, count, full and empty;
  - flush has priority over push in the same cycle.
- The top level holds the FSM, overflow, clear_pend and term_flag.

## Test plan
- Auto mode, TERM_EN=1: push 8'h31, UART model raises busy 1 cycle after tx_send and holds it 10 cycles -> one tx_send with tx_data=8'h31 in cycle 2, no terminator, draining falls after busy drops.
- Batch mode: push 8'h41, 8'h42, 8'h43, then pulse send -> tx_data sequence 8'h41, 8'h42, 8'h43, 8'h0D, one tx_send each, never issued while tx_busy=1.
- DEPTH=4: push 5 keys in batch mode with no send -> count=4, full=1, overflow=1, first 4 keys retained in order; clear -> count=0, overflow=0.
- Full FIFO mid-drain: push in the same cycle as a LOAD pop -> push accepted, count stays 4, overflow stays 0.
- clear during WAIT_DONE of the 2nd of 4 batch bytes -> byte 2 completes, no bytes 3, 4 or terminator, FSM returns to IDLE.
- rst asserted during WAIT_ACK -> next cycle all outputs at reset values; a later send with an empty FIFO produces no tx_send.
